// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Purpose  : RV32I decode stage. Decodes control, reads the 32x32 register
//             file, sign-extends the immediate and captures everything in the
//             D/E pipeline register. Owns the writeback write port.
//  Options  : DECODE_BYPASS_EN - when defined, a read of the register being
//             written back in the same cycle returns ResultW (write-first).
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic [XLEN-1:0] r_rf [32];

    logic [6:0]      w_op;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_regwrite;
    logic            w_memwrite;
    logic            w_jump;
    logic            w_branch;
    logic            w_alusrc;
    logic [1:0]      w_resultsrc;
    logic [1:0]      w_aluop;
    logic [2:0]      w_aluctl;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    assign w_op     = InstrD[6:0];
    assign w_funct3 = InstrD[14:12];
    assign w_rs1    = InstrD[19:15];
    assign w_rs2    = InstrD[24:20];
    assign w_rd     = InstrD[11:7];

    // Register file: reset clears every entry; reset wins over a pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            r_rf[RdW] <= ResultW;
        end
    end

    // Read ports: x0 is hard-wired to zero; optional write-first forwarding.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rs1 != 5'd0) begin
            w_rd1 = r_rf[w_rs1];
`ifdef DECODE_BYPASS_EN
            if (RegWriteW && (RdW == w_rs1)) begin
                w_rd1 = ResultW;
            end
`endif
        end
        if (w_rs2 != 5'd0) begin
            w_rd2 = r_rf[w_rs2];
`ifdef DECODE_BYPASS_EN
            if (RegWriteW && (RdW == w_rs2)) begin
                w_rd2 = ResultW;
            end
`endif
        end
    end

    // Main decoder and immediate generator, both keyed on the opcode.
    always_comb begin
        w_regwrite  = 1'b0;
        w_memwrite  = 1'b0;
        w_jump      = 1'b0;
        w_branch    = 1'b0;
        w_alusrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_aluop     = 2'b00;
        w_imm       = '0;
        case (w_op)
            c_OP_LW: begin
                w_regwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_resultsrc = 2'b01;
                w_imm       = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            c_OP_SW: begin
                w_memwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_imm       = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            end
            c_OP_R: begin
                w_regwrite  = 1'b1;
                w_aluop     = 2'b10;
            end
            c_OP_I: begin
                w_regwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_aluop     = 2'b10;
                w_imm       = {{20{InstrD[31]}}, InstrD[31:20]};
            end
            c_OP_BEQ: begin
                w_branch    = 1'b1;
                w_aluop     = 2'b01;
                w_imm       = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25],
                               InstrD[11:8], 1'b0};
            end
            c_OP_JAL: begin
                w_regwrite  = 1'b1;
                w_jump      = 1'b1;
                w_resultsrc = 2'b10;
                w_imm       = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20],
                               InstrD[30:21], 1'b0};
            end
            default: begin
                w_regwrite  = 1'b0;
            end
        endcase
    end

    // ALU control: funct3/funct7 only matter for the arithmetic opcodes.
    always_comb begin
        w_aluctl = c_ALU_ADD;
        case (w_aluop)
            2'b01: w_aluctl = c_ALU_SUB;
            2'b10: begin
                case (w_funct3)
                    3'b000:  w_aluctl = (w_op[5] && InstrD[30]) ? c_ALU_SUB : c_ALU_ADD;
                    3'b010:  w_aluctl = c_ALU_SLT;
                    3'b110:  w_aluctl = c_ALU_OR;
                    3'b111:  w_aluctl = c_ALU_AND;
                    default: w_aluctl = c_ALU_ADD;
                endcase
            end
            default: w_aluctl = c_ALU_ADD;
        endcase
    end

    // D/E pipeline register: reset and flush both insert an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 3'b000;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            RdE         <= 5'd0;
        end else begin
            RegWriteE   <= w_regwrite;
            MemWriteE   <= w_memwrite;
            JumpE       <= w_jump;
            BranchE     <= w_branch;
            ALUSrcE     <= w_alusrc;
            ResultSrcE  <= w_resultsrc;
            ALUControlE <= w_aluctl;
            RD1E        <= w_rd1;
            RD2E        <= w_rd2;
            ImmExtE     <= w_imm;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            Rs1E        <= w_rs1;
            Rs2E        <= w_rs2;
            RdE         <= w_rd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Purpose  : Self-checking bench for decode_stage: directed vector table,
//             reset/x0/reset-over-write sequences, and random instructions
//             compared against an opcode-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RdW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;

    int checks   = 0;
    int failures = 0;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, imm, pc, pcp4;
        logic [4:0]  rs1, rs2, rd;
    } eout_t;

    eout_t act, exp_o;
    always_comb act = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
                       ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

    // Architectural register state as the bench believes it to be.
    logic [31:0] m_rf [32];

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef DECODE_BYPASS_EN
        if (RegWriteW && RdW == a) return ResultW;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [2:0] m_arith(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[6:0] == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // What the E register should hold after the coming edge.
    function automatic eout_t m_decode();
        eout_t e;
        logic [31:0] ins;
        logic [31:0] ishift;
        ins = InstrD;
        e = '0;
        if (!reset || FlushE) return e;
        ishift = $signed(ins) >>> 20;
        e.pc = PCD; e.pcp4 = PCPlus4D;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.rd1 = m_read(ins[19:15]);
        e.rd2 = m_read(ins[24:20]);
        case (ins[6:0])
            7'b0000011: begin e.rw = 1; e.as = 1; e.rs = 2'b01; e.imm = ishift; end
            7'b0100011: begin e.mw = 1; e.as = 1; e.imm = (ishift & 32'hFFFF_FFE0) | 32'(ins[11:7]); end
            7'b0110011: begin e.rw = 1; e.ac = m_arith(ins); end
            7'b0010011: begin e.rw = 1; e.as = 1; e.ac = m_arith(ins); e.imm = ishift; end
            7'b1100011: begin e.b = 1; e.ac = 3'b001;
                              e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0}; end
            7'b1101111: begin e.rw = 1; e.j = 1; e.rs = 2'b10;
                              e.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
            default:    e.imm = 32'd0;
        endcase
        return e;
    endfunction

    task automatic set_in(input logic [31:0] ins, input logic wen, input logic [4:0] rd,
                          input logic [31:0] res, input logic fl, input logic rst_n);
        logic [31:0] pc;
        pc = $urandom();
        InstrD = ins; RegWriteW = wen; RdW = rd; ResultW = res;
        FlushE = fl; reset = rst_n; PCD = pc; PCPlus4D = pc + 32'd4;
    endtask

    // One clock: predict, advance, update the model, then compare everything.
    task automatic step(input string tag);
        exp_o = m_decode();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (RegWriteW && RdW != 5'd0) begin
            m_rf[RdW] = ResultW;
        end
        #1;
        checks++;
        if (act !== exp_o) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp_o);
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        flush;
        logic [9:0]  ctl;
        logic [31:0] imm;
        logic [31:0] rd1;
    } vec_t;

    vec_t vt[17];

    initial begin
        logic [31:0] rbits;
        logic [6:0]  ops [7];
        logic [9:0]  actl;

        for (int i = 0; i < 32; i++) m_rf[i] = 32'hBAD0_0000 | i;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ops[6] = 7'b1110011;

        //         instr          wen rd  res            fl  ctl              imm            rd1
        vt[0]  = '{32'h00500093, 0, 0, 32'h0,         0, 10'b1000100000, 32'd5,         32'd0};
        vt[1]  = '{32'hFE208CE3, 0, 0, 32'h0,         0, 10'b0001000001, 32'hFFFFFFF8,  32'd0};
`ifdef DECODE_BYPASS_EN
        vt[2]  = '{32'h00010133, 1, 2, 32'hDEADBEEF,  0, 10'b1000000000, 32'd0,         32'hDEADBEEF};
`else
        vt[2]  = '{32'h00010133, 1, 2, 32'hDEADBEEF,  0, 10'b1000000000, 32'd0,         32'd0};
`endif
        vt[3]  = '{32'h00010133, 0, 0, 32'h0,         0, 10'b1000000000, 32'd0,         32'hDEADBEEF};
        vt[4]  = '{32'h00112223, 0, 0, 32'h0,         0, 10'b0100100000, 32'd4,         32'hDEADBEEF};
        vt[5]  = '{32'h00000093, 1, 0, 32'h12345678,  0, 10'b1000100000, 32'd0,         32'd0};
        vt[6]  = '{32'h00000093, 0, 0, 32'h0,         0, 10'b1000100000, 32'd0,         32'd0};
        vt[7]  = '{32'h008000EF, 0, 0, 32'h0,         0, 10'b1010010000, 32'd8,         32'd0};
        vt[8]  = '{32'h40208033, 0, 0, 32'h0,         0, 10'b1000000001, 32'd0,         32'd0};
        vt[9]  = '{32'h40000093, 0, 0, 32'h0,         0, 10'b1000100000, 32'h400,       32'd0};
        vt[10] = '{32'h0020F1B3, 0, 0, 32'h0,         0, 10'b1000000010, 32'd0,         32'd0};
        vt[11] = '{32'h0020A1B3, 0, 0, 32'h0,         0, 10'b1000000101, 32'd0,         32'd0};
        vt[12] = '{32'h0020E1B3, 0, 0, 32'h0,         0, 10'b1000000011, 32'd0,         32'd0};
        vt[13] = '{32'h0000A283, 0, 0, 32'h0,         0, 10'b1000101000, 32'd0,         32'd0};
        vt[14] = '{32'h0000A283, 0, 0, 32'h0,         1, 10'b0000000000, 32'd0,         32'd0};
        vt[15] = '{32'h0000007F, 0, 0, 32'h0,         0, 10'b0000000000, 32'd0,         32'd0};
        vt[16] = '{32'h00000000, 0, 0, 32'h0,         0, 10'b0000000000, 32'd0,         32'd0};

        set_in(32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset held for two cycles with random inputs, writes included.
        for (int i = 0; i < 2; i++) begin
            rbits = $urandom();
            set_in($urandom(), 1'b1, rbits[4:0] | 5'd1, $urandom(), rbits[5], 1'b0);
            step($sformatf("reset%0d", i));
        end

        // Every register reads back zero after reset.
        for (int i = 1; i < 32; i++) begin
            set_in({7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011}, 0, 0, 0, 0, 1);
            step($sformatf("rdzero_x%0d", i));
        end

        // Directed table with literal expectations for the key fields.
        for (int v = 0; v < 17; v++) begin
            set_in(vt[v].instr, vt[v].wen, vt[v].rd, vt[v].res, vt[v].flush, 1'b1);
            step($sformatf("model_vec%0d", v));
            actl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
            checks++;
            if (actl !== vt[v].ctl || ImmExtE !== vt[v].imm || RD1E !== vt[v].rd1) begin
                failures++;
                $display("FAIL vec%0d ctl=%b imm=%h rd1=%h required ctl=%b imm=%h rd1=%h",
                         v, actl, ImmExtE, RD1E, vt[v].ctl, vt[v].imm, vt[v].rd1);
            end
        end

        // Flush with a coincident writeback: the write must still land.
        set_in(32'h00000013, 1, 5'd7, 32'hCAFE0007, 1, 1);
        step("flush_wb");
        set_in({12'd0, 5'd7, 3'd0, 5'd1, 7'b0010011}, 0, 0, 0, 0, 1);
        step("flush_wb_read");
        checks++;
        if (RD1E !== 32'hCAFE0007) begin
            failures++;
            $display("FAIL flush_wb_commit act=%h req=%h", RD1E, 32'hCAFE0007);
        end

        // Random instructions, writebacks, flushes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [31:0] ctl;
            rbits = $urandom();
            ctl   = $urandom();
            ins   = {rbits[31:7], ops[$urandom_range(0, 6)]};
            set_in(ins, ctl[0], ctl[5:1], $urandom(), (ctl[9:7] == 3'd0),
                   (ctl[15:10] != 6'd0));
            step($sformatf("rand%0d", n));
        end

        // Reset wins over a writeback in the same cycle.
        set_in(32'h0, 1, 5'd5, 32'h00000055, 0, 1);
        step("pre_reset_wb");
        set_in(32'h0, 1, 5'd5, 32'h00000077, 0, 0);
        step("reset_wb");
        set_in({7'd0, 5'd5, 5'd5, 3'd0, 5'd0, 7'b0110011}, 0, 0, 0, 0, 1);
        step("reset_wb_read");
        checks++;
        if (RD1E !== 32'd0 || RD2E !== 32'd0) begin
            failures++;
            $display("FAIL reset_over_write rd1=%h rd2=%h req=0", RD1E, RD2E);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage pipelined RV32I core. It consumes the fetch-stage outputs `InstrD`, `PCD` and `PCPlus4D`, decodes control, reads the 32x32 register file, and sign-extends the immediate. It captures everything in the D/E pipeline register that feeds the execute stage. It also owns the register-file write port driven by the writeback stage.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.

Ports:
- `clk`  in  1  core clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `InstrD`  in  32  instruction from fetch.
- `PCD`  in  32  PC of `InstrD`.
- `PCPlus4D`  in  32  PC+4 of `InstrD`.
- `RegWriteW`  in  1  writeback enable.
- `RdW`  in  5  writeback destination register.
- `ResultW`  in  32  writeback data.
- `FlushE`  in  1  replaces the next E-register contents with a bubble.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`  out  1 each  execute controls.
- `ResultSrcE`  out  2  result source: 00 ALU, 01 memory, 10 PC+4.
- `ALUControlE`  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E`  out  32 each  execute data.
- `Rs1E`, `Rs2E`, `RdE`  out  5 each  register indices, for the hazard unit.

## Operation
Register file:
- 32 entries of 32 bits.
- Synchronous reset clears all entries to 0.
- Writes occur on the rising edge when `RegWriteW`=1 and `RdW`≠0.
- Reads of x0 always return 0.

Decoder (opcode):
- `0000011` lw: RegWrite=1, ALUSrc=1, ResultSrc=01, ALUOp=00.
- `0100011` sw: MemWrite=1, ALUSrc=1, ALUOp=00.
- `0110011` R-type: RegWrite=1, ALUOp=10.
- `0010011` I-ALU: RegWrite=1, ALUSrc=1, ALUOp=10.
- `1100011` beq: Branch=1, ALUOp=01.
- `1101111` jal: RegWrite=1, Jump=1, ResultSrc=10.
- Any other opcode, including the 0x00000000 fetch emits after reset: all controls 0, which is a bubble.

ALU control:
- ALUOp 00 → add.
- ALUOp 01 → sub.
- ALUOp 10, selected by funct3:
  - 000 → sub when op[5]&funct7[5], else add.
  - 010 → slt.
  - 110 → or.
  - 111 → and.
  - other → add.

Immediate, sign-extended from instr[31] by opcode class:
- I-type: `{instr[31:20]}`.
- S-type: `{instr[31:25],instr[11:7]}`.
- B-type: `{instr[31],instr[7],instr[30:25],instr[11:8],0}`.
- J-type: `{instr[31],instr[19:12],instr[20],instr[30:21],0}`.
- R-type and unknown opcodes: 0.

Index fields:
- `Rs1`=instr[19:15], `Rs2`=instr[24:20], `Rd`=instr[11:7].
- These are passed through unconditionally.

D/E register:
- Loaded every cycle with the decoded values.
- Priority: `reset`=0 > `FlushE`=1 > normal load.
- Both reset and flush drive every E output, control and data, to 0.

## Timing
- Latency: `InstrD` presented in cycle N appears decoded on the E outputs after the edge ending cycle N.
- Reset: all outputs are 0 on the first edge with `reset`=0. Register-file contents are 0 on the same edge.
- Reset mid-operation: any pending writeback in the reset cycle is discarded, because reset takes precedence over the write.
- Flush: `FlushE`=1 in cycle N makes the E outputs all 0 after that edge. A writeback in the same cycle still commits.
- Write to x0: discarded, and never bypassed.
- No stall input: the block accepts a new instruction every cycle.

## Configuration
Macro `DECODE_BYPASS_EN`.
- Defined: a read whose index equals `RdW` while `RegWriteW`=1 and `RdW`≠0 returns `ResultW` in the same cycle (write-first).
- Undefined: that read returns the old register value. The hazard unit must then cover the writeback-to-decode case by stalling.

## Test plan
1. Reset: hold `reset`=0 for 2 cycles with random inputs → every E output is 0, and reads of x1..x31 return 0.
2. Decode addi: `InstrD`=0x00500093 (addi x1,x0,5) → `RegWriteE`=1, `ALUSrcE`=1, `ALUControlE`=000, `ImmExtE`=5, `RdE`=1, `RD1E`=0.
3. Branch immediate and ALU op: `InstrD`=0xFE208CE3 (beq x1,x2,-8) → `BranchE`=1, `ALUControlE`=001, `ImmExtE`=0xFFFFFFF8, `Rs1E`=1, `Rs2E`=2, `RegWriteE`=0.
4. Writeback and bypass:
   - Stimulus: write x2=0xDEADBEEF via `RegWriteW`/`RdW`=2 in the same cycle as `InstrD`=0x00010133 (add x2,x2,x0).
   - With the macro defined → `RD1E`=0xDEADBEEF.
   - Without it → `RD1E`=0.
   - In both builds, a read of x2 in the following cycle returns 0xDEADBEEF.
5. x0 protection: write x0=0x12345678, then decode an instruction reading x0 → `RD1E`=0.
6. Flush and illegal opcode: `FlushE`=1 with a valid lw `InstrD`=0x0000A283 → all E outputs 0. Next, `InstrD`=0x0000007F → all control outputs 0.
